// File: rtl/modulador_pkg.sv
// modulador_pkg: shared FSM state type and sine-table helper functions for the FSK modulator.
//   midscale(w)   : 2^(w-1), the zero level of an unsigned w-bit sample
//   full_scale(w) : 2^w-1, the upper clamp for a w-bit sample
//   sine_entry()  : one entry of the offset sine table, evaluated at elaboration
package modulador_pkg;

    typedef enum logic {IDLE, SEND} estado_t;

    localparam real PI = 3.14159265358979323846;

    function automatic int midscale(input int out_w);
        return 1 << (out_w - 1);
    endfunction

    function automatic int full_scale(input int out_w);
        return (1 << out_w) - 1;
    endfunction

    // Taylor series after folding the angle into [-pi, pi]; 12 terms keep the
    // error far below one LSB for any practical sample width.
    function automatic real sin_aprox(input real x);
        real y, y2, termo, soma;
        y = (x > PI) ? x - 2.0 * PI : x;
        y2 = y * y;
        termo = y;
        soma = y;
        for (int n = 1; n < 12; n++) begin
            termo = -termo * y2 / real'((2 * n) * (2 * n + 1));
            soma = soma + termo;
        end
        return soma;
    endfunction

    function automatic int sine_entry(input int k, input int out_w, input int lut_aw);
        real ang, v;
        int r;
        ang = 2.0 * PI * real'(k) / real'(1 << lut_aw);
        v = real'(midscale(out_w)) * (1.0 + sin_aprox(ang));
        r = $rtoi(v + 0.5);
        return (r < 0) ? 0 : (r > full_scale(out_w)) ? full_scale(out_w) : r;
    endfunction

endpackage

// File: rtl/seno_lut.sv
// seno_lut: registered sine table built at elaboration.
//   clk, reset : clock and synchronous active-high reset (output returns to midscale)
//   en         : load a new sample this cycle, otherwise hold
//   addr       : table index (LUT_AW bits)
//   q          : unsigned offset-binary sample (OUT_W bits)
module seno_lut
    import modulador_pkg::*;
#(
    parameter int OUT_W  = 8,
    parameter int LUT_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [LUT_AW-1:0] addr,
    output logic [OUT_W-1:0]  q
);

    logic [OUT_W-1:0] tabela [2**LUT_AW];

    for (genvar k = 0; k < 2**LUT_AW; k++) begin : g_tab
        localparam int V = sine_entry(k, OUT_W, LUT_AW);
        assign tabela[k] = OUT_W'(V);
    end

    always_ff @(posedge clk) begin
        if (reset)
            q <= OUT_W'(midscale(OUT_W));
        else if (en)
            q <= tabela[addr];
    end

endmodule

// File: rtl/modulador_fsk.sv
// modulador_fsk: continuous-phase binary FSK modulator with valid/ready bit input.
//   clk, reset             : clock and synchronous active-high reset
//   enable                 : advances phase, bit counter and output sample
//   dado, dado_valid       : bit to send and its offer strobe
//   dado_ready             : bit accepted when dado_valid & dado_ready
//   tw_mark, tw_space      : phase increments for bit 1 / bit 0 (mark also idles)
//   bit_period             : enabled clocks per bit (0 behaves as 1)
//   saida, saida_valid     : unsigned sine sample and its update strobe
//   busy                   : a bit is being sent
//   underrun               : one-cycle pulse when a bit ends with no successor
module modulador_fsk
    import modulador_pkg::*;
#(
    parameter int OUT_W   = 8,
    parameter int PHASE_W = 16,
    parameter int LUT_AW  = 5,
    parameter int PER_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               dado,
    input  logic               dado_valid,
    output logic               dado_ready,
    input  logic [PHASE_W-1:0] tw_mark,
    input  logic [PHASE_W-1:0] tw_space,
    input  logic [PER_W-1:0]   bit_period,
    output logic [OUT_W-1:0]   saida,
    output logic               saida_valid,
    output logic               busy,
    output logic               underrun
);

    estado_t            estado;
    logic [PHASE_W-1:0] fase;
    logic [PHASE_W-1:0] tw_cur;
    logic [PER_W-1:0]   cont;
    logic [PER_W-1:0]   periodo;
    logic               ultimo;
    logic               transf;

    assign ultimo     = (estado == SEND) && (cont == periodo);
    assign dado_ready = !reset && enable && ((estado == IDLE) || ultimo);
    assign transf     = dado_ready && dado_valid;
    assign busy       = !reset && (estado == SEND);

    // The accumulator is never touched at bit boundaries: only the increment
    // changes, which keeps the output phase continuous.
    always_ff @(posedge clk) begin
        if (reset) begin
            fase        <= '0;
            tw_cur      <= '0;
            cont        <= '0;
            periodo     <= '0;
            estado      <= IDLE;
            saida_valid <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            saida_valid <= enable;
            underrun    <= enable && ultimo && !transf;
            if (enable) begin
                fase <= fase + tw_cur;
                if (transf) begin
                    estado  <= SEND;
                    cont    <= PER_W'(1);
                    periodo <= (bit_period == '0) ? PER_W'(1) : bit_period;
                    tw_cur  <= dado ? tw_mark : tw_space;
                end else if ((estado == IDLE) || ultimo) begin
                    estado <= IDLE;
                    cont   <= '0;
                    tw_cur <= tw_mark;
                end else begin
                    cont <= cont + PER_W'(1);
                end
            end
        end
    end

    seno_lut #(
        .OUT_W (OUT_W),
        .LUT_AW(LUT_AW)
    ) u_lut (
        .clk  (clk),
        .reset(reset),
        .en   (enable),
        .addr (fase[PHASE_W-1 -: LUT_AW]),
        .q    (saida)
    );

endmodule

// File: tb/tb_modulador_fsk.sv
// tb_modulador_fsk: directed and random checks of modulador_fsk against a behavioural model.
module tb_modulador_fsk;

    localparam int OUT_W = 8, PHASE_W = 16, LUT_AW = 5, PER_W = 16;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               enable = 1'b0;
    logic               dado = 1'b0;
    logic               dado_valid = 1'b0;
    logic [PHASE_W-1:0] tw_mark = '0;
    logic [PHASE_W-1:0] tw_space = '0;
    logic [PER_W-1:0]   bit_period = '0;
    logic               dado_ready;
    logic [OUT_W-1:0]   saida;
    logic               saida_valid;
    logic               busy;
    logic               underrun;

    always #5 clk = ~clk;

    modulador_fsk #(
        .OUT_W  (OUT_W),
        .PHASE_W(PHASE_W),
        .LUT_AW (LUT_AW),
        .PER_W  (PER_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .dado       (dado),
        .dado_valid (dado_valid),
        .dado_ready (dado_ready),
        .tw_mark    (tw_mark),
        .tw_space   (tw_space),
        .bit_period (bit_period),
        .saida      (saida),
        .saida_valid(saida_valid),
        .busy       (busy),
        .underrun   (underrun)
    );

    int tbl[32];
    int n_chk = 0;
    int n_fail = 0;

    // Model: phase, tone in use, bit in flight and enabled cycles left in it.
    int m_fase, m_tom, m_rest, m_saida;
    bit m_env, m_valid, m_under;
    int n_under, vmax, vmin;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_fase = 0; m_tom = 0; m_rest = 0; m_saida = 128;
        m_env = 0; m_valid = 0; m_under = 0;
    endtask

    task automatic step();
        bit m_ready, fim, xfer;
        @(negedge clk);
        m_ready = !reset && enable && (!m_env || m_rest == 1);
        check("saida", saida, m_saida);
        check("saida_valid", saida_valid, m_valid);
        check("busy", busy, m_env && !reset);
        check("dado_ready", dado_ready, m_ready);
        check("underrun", underrun, m_under);
        if (underrun === 1'b1) n_under++;
        if (int'(saida) > vmax) vmax = int'(saida);
        if (int'(saida) < vmin) vmin = int'(saida);
        fim  = m_env && m_rest == 1;
        xfer = m_ready && dado_valid;
        if (reset) begin
            model_reset();
        end else if (enable) begin
            m_saida = tbl[m_fase / 2048];
            m_valid = 1;
            m_under = fim && !xfer;
            m_fase  = (m_fase + m_tom) % 65536;
            if (xfer) begin
                m_env  = 1;
                m_rest = (bit_period == 0) ? 1 : int'(bit_period);
                m_tom  = dado ? int'(tw_mark) : int'(tw_space);
            end else if (fim) begin
                m_env = 0;
                m_tom = int'(tw_mark);
            end else if (m_env) begin
                m_rest--;
            end else begin
                m_tom = int'(tw_mark);
            end
        end else begin
            m_valid = 0;
            m_under = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    initial begin
        for (int k = 0; k < 32; k++) begin
            int r;
            r = $rtoi(128.0 * (1.0 + $sin(2.0 * 3.14159265358979 * k / 32.0)) + 0.5);
            tbl[k] = (r > 255) ? 255 : (r < 0) ? 0 : r;
        end
        n_under = 0;
        model_reset();
        @(posedge clk);
        #1;
        run(2);
        check("rst_saida", saida, 128);

        // idle mark tone
        reset = 0; enable = 1; tw_mark = 3072; tw_space = 2048;
        run(6);

        // single space bit of 32 cycles from phase 0
        reset = 1; step(); reset = 0;
        vmax = 0; vmin = 255;
        dado = 0; dado_valid = 1; bit_period = 32;
        step();
        dado_valid = 0;
        run(34);
        check("space_peak", vmax, 255);
        check("space_trough", vmin, 0);
        check("underrun_after_space", n_under, 1);

        // back-to-back 0 then 1, then valid dropped
        dado = 0; dado_valid = 1; bit_period = 8;
        step();
        dado = 1;
        run(8);
        check("busy_at_boundary", busy, 1);
        dado_valid = 0;
        tw_space = 1000; bit_period = 3;
        run(10);
        check("underrun_after_pair", n_under, 2);

        // enable low five cycles mid-bit
        dado = 0; dado_valid = 1; bit_period = 10; tw_space = 2048;
        step();
        dado_valid = 0;
        run(3);
        enable = 0;
        run(5);
        check("frozen_busy", busy, 1);
        enable = 1;
        run(10);
        check("underrun_after_freeze", n_under, 3);

        // reset mid-bit, then a zero-period bit
        dado = 1; dado_valid = 1; bit_period = 20;
        step();
        dado_valid = 0;
        run(5);
        reset = 1; step(); reset = 0;
        check("abort_saida", saida, 128);
        bit_period = 0; dado = 0; dado_valid = 1;
        step();
        dado_valid = 0;
        run(4);
        check("underrun_after_abort", n_under, 4);

        // longest period, counter must not wrap
        dado = 1; dado_valid = 1; bit_period = 16'hFFFF;
        step();
        dado_valid = 0;
        run(65537);
        check("underrun_after_long", n_under, 5);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            reset      = ($urandom_range(0, 99) == 0);
            enable     = ($urandom_range(0, 4) != 0);
            dado       = 1'($urandom);
            dado_valid = ($urandom_range(0, 3) != 0);
            tw_mark    = 16'($urandom);
            tw_space   = 16'($urandom);
            bit_period = 16'($urandom_range(0, 6));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
